lamp_shift_driver: RTL and testbench

- Downstream consumer of the bound flasher's parallel lamp vector.
- Serializes the lamp vector onto a 3-wire interface (sclk/sdata/slatch) for an external chain of serial-in/parallel-out LED driver registers.
- Sends a frame only when the lamp pattern changes, once after reset, and optionally on a periodic refresh.
- Coalesces updates that arrive while a frame is in flight, so only the newest pattern is sent.

---
 rtl/lamp_shift_driver.sv | 169 ++++++++++++++++
 tb/tb_lamp_shift_driver.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_shift_driver.sv
// Serializes the lamp vector onto a sclk/sdata/slatch chain, one frame per pattern change or after reset.
// Optional periodic refresh frames are compiled in with `define LAMP_SHIFT_REFRESH_EN.
module lamp_shift_driver #(
    parameter int MX_LP          = 16,
    parameter int CLK_DIV        = 2,
    parameter int MSB_FIRST      = 1,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MX_LP-1:0] lamp_in,
    output logic             sclk,
    output logic             sdata,
    output logic             slatch,
    output logic             busy,
    output logic             frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (MX_LP > 1) ? $clog2(MX_LP) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(MX_LP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t           state_q;
    logic [MX_LP-1:0] last_sent_q;
    logic [MX_LP-1:0] shift_q;
    logic             init_pending_q;
    logic [PW-1:0]    phase_q;
    logic [BW-1:0]    bit_q;
    logic             half_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             slatch_q;
    logic             busy_q;
    logic             frame_done_q;

    logic [MX_LP-1:0] shift_d;
    logic             next_bit_d;
    logic             first_bit_d;
    logic [PW-1:0]    phase_d;
    logic             refresh_due;
    logic             trigger;

    // The register always presents its next outgoing bit at the edge that feeds sdata.
    always_comb begin
        shift_d     = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
        next_bit_d  = (MSB_FIRST != 0) ? shift_q[MX_LP-2] : shift_q[1];
        first_bit_d = (MSB_FIRST != 0) ? lamp_in[MX_LP-1] : lamp_in[0];
        phase_d     = phase_q + PW'(1);
    end

`ifdef LAMP_SHIFT_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    logic [RW-1:0] idle_cnt_q;

    assign refresh_due = (idle_cnt_q == RW'(REFRESH_CYCLES));

    // Counts untriggered IDLE cycles; any trigger means LOAD is next, which restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (trigger) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + RW'(1);
            end
        end
    end
`else
    assign refresh_due = 1'b0;
`endif

    assign trigger = (lamp_in != last_sent_q) || init_pending_q || refresh_due;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            last_sent_q    <= '0;
            shift_q        <= '0;
            init_pending_q <= 1'b1;
            phase_q        <= '0;
            bit_q          <= '0;
            half_q         <= 1'b0;
            sclk_q         <= 1'b0;
            sdata_q        <= 1'b0;
            slatch_q       <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sclk_q       <= 1'b0;
                    sdata_q      <= 1'b0;
                    slatch_q     <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= trigger;
                    if (trigger) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q        <= lamp_in;
                    last_sent_q    <= lamp_in;
                    init_pending_q <= 1'b0;
                    sdata_q        <= first_bit_d;
                    sclk_q         <= 1'b0;
                    phase_q        <= '0;
                    bit_q          <= '0;
                    half_q         <= 1'b0;
                    state_q        <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (phase_q != PH_LAST) begin
                        phase_q <= phase_d;
                    end else begin
                        phase_q <= '0;
                        if (!half_q) begin
                            half_q <= 1'b1;
                            sclk_q <= 1'b1;
                        end else if (bit_q == BIT_LAST) begin
                            half_q       <= 1'b0;
                            sclk_q       <= 1'b0;
                            slatch_q     <= 1'b1;
                            frame_done_q <= (PH_LAST == '0);
                            state_q      <= S_LATCH;
                        end else begin
                            half_q  <= 1'b0;
                            sclk_q  <= 1'b0;
                            bit_q   <= bit_q + BW'(1);
                            shift_q <= shift_d;
                            sdata_q <= next_bit_d;
                        end
                    end
                end
                S_LATCH: begin
                    if (phase_q != PH_LAST) begin
                        phase_q      <= phase_d;
                        frame_done_q <= (phase_d == PH_LAST);
                    end else begin
                        phase_q      <= '0;
                        slatch_q     <= 1'b0;
                        sdata_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign slatch     = slatch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lamp_shift_driver.sv
// Directed bench for lamp_shift_driver: an MSB-first CLK_DIV=2 instance plus an LSB-first CLK_DIV=1 instance.
// Build with LAMP_SHIFT_REFRESH_EN defined to run the refresh scenario instead of the quiescence one.
module tb_lamp_shift_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lampA = 16'h0000;
    logic [15:0] lampB = 16'h0000;
    logic        sclkA, sdataA, slatchA, busyA, doneA;
    logic        sclkB, sdataB, slatchB, busyB, doneB;

    int testsRun = 0;
    int testsFailed = 0;

    lamp_shift_driver #(
        .MX_LP(16), .CLK_DIV(2), .MSB_FIRST(1), .REFRESH_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .lamp_in(lampA),
        .sclk(sclkA), .sdata(sdataA), .slatch(slatchA), .busy(busyA), .frame_done(doneA)
    );

    lamp_shift_driver #(
        .MX_LP(16), .CLK_DIV(1), .MSB_FIRST(0), .REFRESH_CYCLES(100)
    ) dutLsb (
        .clk(clk), .rst(rst), .lamp_in(lampB),
        .sclk(sclkB), .sdata(sdataB), .slatch(slatchB), .busy(busyB), .frame_done(doneB)
    );

    always #5 clk = ~clk;

    // Frame receivers: rebuild each frame from sdata at sclk rising edges, sampled on the falling clock edge.
    logic [15:0] curFrameA = '0, curFrameB = '0;
    int curBitsA = 0, curBitsB = 0;
    logic prevSclkA = 0, prevSlatchA = 0, prevSclkB = 0, prevSlatchB = 0;
    logic [15:0] framesA[$];
    logic [15:0] framesB[$];
    int bitsA[$];
    int bitsB[$];
    int edgesA = 0, latchPulsesA = 0, latchCyclesA = 0, doneCyclesA = 0, busyCyclesA = 0;
    int busyCyclesB = 0;

    always @(negedge clk) begin
        if (rst) begin
            curFrameA = '0; curBitsA = 0; prevSclkA = 0; prevSlatchA = 0;
        end else begin
            if (sclkA && !prevSclkA) begin
                curFrameA = {curFrameA[14:0], sdataA};
                curBitsA++;
                edgesA++;
            end
            if (slatchA && !prevSlatchA) begin
                framesA.push_back(curFrameA);
                bitsA.push_back(curBitsA);
                curBitsA = 0;
                latchPulsesA++;
            end
            if (slatchA) latchCyclesA++;
            if (doneA) doneCyclesA++;
            if (busyA) busyCyclesA++;
            prevSclkA = sclkA;
            prevSlatchA = slatchA;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            curFrameB = '0; curBitsB = 0; prevSclkB = 0; prevSlatchB = 0;
        end else begin
            if (sclkB && !prevSclkB) begin
                curFrameB = {sdataB, curFrameB[15:1]};
                curBitsB++;
            end
            if (slatchB && !prevSlatchB) begin
                framesB.push_back(curFrameB);
                bitsB.push_back(curBitsB);
                curBitsB = 0;
            end
            if (busyB) busyCyclesB++;
            prevSclkB = sclkB;
            prevSlatchB = slatchB;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitFrameA(input int target, output bit ok);
        int n = 0;
        while (!(framesA.size() >= target && !busyA) && n < 2000) begin
            tick();
            n++;
        end
        ok = (framesA.size() >= target && !busyA);
    endtask

    task automatic waitFrameB(input int target, output bit ok);
        int n = 0;
        while (!(framesB.size() >= target && !busyB) && n < 2000) begin
            tick();
            n++;
        end
        ok = (framesB.size() >= target && !busyB);
    endtask

    task automatic waitEdgesA(input int target, output bit ok);
        int n = 0;
        while (edgesA < target && n < 1000) begin
            tick();
            n++;
        end
        ok = (edgesA >= target);
    endtask

    task automatic test_reset();
        bit ok;
        int baseBusy, baseEdges, baseFrames, baseLatch, baseDone;
        rst = 1'b1;
        lampA = 16'h0000;
        lampB = 16'h0000;
        tick();
        tick();
        testsRun++;
        if ({sclkA, sdataA, slatchA, busyA, doneA} !== 5'b00000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000", {sclkA, sdataA, slatchA, busyA, doneA});
        end
        baseBusy = busyCyclesA; baseEdges = edgesA; baseFrames = framesA.size();
        baseLatch = latchCyclesA; baseDone = doneCyclesA;
        rst = 1'b0;
        testsRun++;
        if (busyA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy_first: got %b expected 0", busyA);
        end
        tick();
        testsRun++;
        if (busyA !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy_second: got %b expected 1", busyA);
        end
        waitFrameA(baseFrames + 1, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL reset_frame_timeout: got frames %0d expected %0d", framesA.size(), baseFrames + 1);
        end else begin
            testsRun++;
            if (framesA[baseFrames] !== 16'h0000 || bitsA[baseFrames] != 16) begin
                testsFailed++;
                $display("[TB] FAIL reset_frame_data: got %h/%0d bits expected 0000/16", framesA[baseFrames], bitsA[baseFrames]);
            end
        end
        testsRun++;
        if (busyCyclesA - baseBusy != 67) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy_len: got %0d expected 67", busyCyclesA - baseBusy);
        end
        testsRun++;
        if (edgesA - baseEdges != 16) begin
            testsFailed++;
            $display("[TB] FAIL reset_sclk_edges: got %0d expected 16", edgesA - baseEdges);
        end
        testsRun++;
        if (latchCyclesA - baseLatch != 2) begin
            testsFailed++;
            $display("[TB] FAIL reset_slatch_len: got %0d expected 2", latchCyclesA - baseLatch);
        end
        testsRun++;
        if (doneCyclesA - baseDone != 1) begin
            testsFailed++;
            $display("[TB] FAIL reset_done_len: got %0d expected 1", doneCyclesA - baseDone);
        end
        waitFrameB(1, ok);
    endtask

    task automatic test_bit_order();
        bit ok;
        int baseFrames, basePulses, baseBusyB;
        baseFrames = framesA.size();
        basePulses = latchPulsesA;
        lampA = 16'h8001;
        waitFrameA(baseFrames + 1, ok);
        repeat (3) tick();
        testsRun++;
        if (!ok || framesA[baseFrames] !== 16'h8001 || bitsA[baseFrames] != 16) begin
            testsFailed++;
            $display("[TB] FAIL msb_order: got %h/%0d bits (ok=%0d) expected 8001/16",
                     framesA[framesA.size()-1], bitsA[bitsA.size()-1], ok);
        end
        testsRun++;
        if (latchPulsesA - basePulses != 1) begin
            testsFailed++;
            $display("[TB] FAIL msb_latch_pulses: got %0d expected 1", latchPulsesA - basePulses);
        end
        baseFrames = framesB.size();
        baseBusyB = busyCyclesB;
        lampB = 16'h0003;
        waitFrameB(baseFrames + 1, ok);
        testsRun++;
        if (!ok || framesB[baseFrames] !== 16'h0003 || bitsB[baseFrames] != 16) begin
            testsFailed++;
            $display("[TB] FAIL lsb_order: got %h/%0d bits (ok=%0d) expected 0003/16",
                     framesB[framesB.size()-1], bitsB[bitsB.size()-1], ok);
        end
        testsRun++;
        if (busyCyclesB - baseBusyB != 34) begin
            testsFailed++;
            $display("[TB] FAIL lsb_busy_len: got %0d expected 34", busyCyclesB - baseBusyB);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int baseFrames, baseEdges, gap;
        baseFrames = framesA.size();
        baseEdges = edgesA;
        lampA = 16'h00FF;
        waitEdgesA(baseEdges + 3, ok);
        lampA = 16'h0F0F;
        waitEdgesA(baseEdges + 9, ok);
        lampA = 16'h1234;
        waitFrameA(baseFrames + 1, ok);
        gap = 0;
        while (!busyA && gap < 50) begin
            gap++;
            tick();
        end
        testsRun++;
        if (gap != 1) begin
            testsFailed++;
            $display("[TB] FAIL coalesce_idle_gap: got %0d expected 1", gap);
        end
        waitFrameA(baseFrames + 2, ok);
        repeat (20) tick();
        testsRun++;
        if (framesA.size() != baseFrames + 2) begin
            testsFailed++;
            $display("[TB] FAIL coalesce_frame_count: got %0d expected 2", framesA.size() - baseFrames);
        end else begin
            testsRun++;
            if (framesA[baseFrames] !== 16'h00FF) begin
                testsFailed++;
                $display("[TB] FAIL coalesce_first: got %h expected 00ff", framesA[baseFrames]);
            end
            testsRun++;
            if (framesA[baseFrames+1] !== 16'h1234) begin
                testsFailed++;
                $display("[TB] FAIL coalesce_second: got %h expected 1234", framesA[baseFrames+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int baseEdges, basePulses, baseFrames;
        baseEdges = edgesA;
        lampA = 16'hFFFF;
        waitEdgesA(baseEdges + 7, ok);
        tick();
        basePulses = latchPulsesA;
        rst = 1'b1;
        tick();
        testsRun++;
        if ({sclkA, sdataA, slatchA, busyA} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got %b expected 0000", {sclkA, sdataA, slatchA, busyA});
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        testsRun++;
        if (latchPulsesA != basePulses) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_latch: got %0d pulses expected %0d", latchPulsesA, basePulses);
        end
        baseFrames = framesA.size();
        waitFrameA(baseFrames + 1, ok);
        testsRun++;
        if (!ok || framesA[baseFrames] !== 16'hFFFF || bitsA[baseFrames] != 16) begin
            testsFailed++;
            $display("[TB] FAIL midreset_resend: got %h/%0d bits (ok=%0d) expected ffff/16",
                     framesA[framesA.size()-1], bitsA[bitsA.size()-1], ok);
        end
    endtask

`ifndef LAMP_SHIFT_REFRESH_EN
    task automatic test_quiescence();
        bit ok;
        int baseFrames, bad;
        baseFrames = framesA.size();
        lampA = 16'hAAAA;
        waitFrameA(baseFrames + 1, ok);
        testsRun++;
        if (!ok || framesA[baseFrames] !== 16'hAAAA) begin
            testsFailed++;
            $display("[TB] FAIL quiet_frame: got %h (ok=%0d) expected aaaa", framesA[framesA.size()-1], ok);
        end
        bad = 0;
        repeat (500) begin
            tick();
            if (busyA || sclkA || slatchA) bad++;
        end
        testsRun++;
        if (bad != 0 || framesA.size() != baseFrames + 1) begin
            testsFailed++;
            $display("[TB] FAIL quiet_hold: got %0d active cycles, %0d frames expected 0, 1", bad, framesA.size() - baseFrames);
        end
    endtask
`else
    task automatic test_refresh();
        bit ok;
        int baseFrames, baseBusy, gap;
        baseFrames = framesA.size();
        lampA = 16'h5555;
        waitFrameA(baseFrames + 1, ok);
        for (int r = 0; r < 2; r++) begin
            baseFrames = framesA.size();
            baseBusy = busyCyclesA;
            gap = 0;
            while (!busyA && gap < 300) begin
                gap++;
                tick();
            end
            testsRun++;
            if (gap != 101) begin
                testsFailed++;
                $display("[TB] FAIL refresh_gap_%0d: got %0d expected 101", r, gap);
            end
            waitFrameA(baseFrames + 1, ok);
            testsRun++;
            if (!ok || framesA.size() != baseFrames + 1 || framesA[baseFrames] !== 16'h5555 ||
                busyCyclesA - baseBusy != 67) begin
                testsFailed++;
                $display("[TB] FAIL refresh_frame_%0d: got %h, %0d frames, busy %0d expected 5555, 1, 67",
                         r, framesA[framesA.size()-1], framesA.size() - baseFrames, busyCyclesA - baseBusy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_reset_mid();
`ifndef LAMP_SHIFT_REFRESH_EN
        test_quiescence();
`else
        test_refresh();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no completion expected completion before 500000");
        $fatal(1, "[TB] timeout");
    end

endmodule
